// File: rtl/spe_accum_array.sv
// spe_accum_array: gathers one partial sum from each of N_CH PPE channels,
// adds them into a single convolution result and integrates that result into
// the membrane potential of the current output neuron. Potentials live in a
// local array indexed by idx. Every neuron update produces one
// (index, potential, spike) record for the packetizer side.
//
// Handshake rule for every valid/ready pair on this block: a transfer happens
// on a rising clock edge where valid and ready are both high. A source may not
// retract valid or change its payload until that transfer. Ready never
// depends combinationally on valid of the same interface. in_ready[k] is a
// pure function of the channel FIFO fill level. A full FIFO refuses a push
// even when a pop happens in the same cycle.
module spe_accum_array #(
  parameter int N_CH       = 5,
  parameter int SUM_W      = 13,
  parameter int POT_W      = 13,
  parameter int DEPTH      = 8,
  parameter int NUM_OUT    = 441,
  parameter int RESET_MODE = 0,
  localparam int IDX_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*SUM_W-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  ts_done,
  input  logic [POT_W-1:0]      threshold,
  input  logic [POT_W-1:0]      leak,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_idx,
  output logic [POT_W-1:0]      out_potential,
  output logic                  out_spike,
  output logic                  first_ts,
  output logic [1:0]            err,
  output logic [2:0]            dbg_state
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int SUMT_W = SUM_W + $clog2(N_CH);
  localparam int CALC_W = ((SUMT_W > POT_W) ? SUMT_W : POT_W) + 2;

  localparam logic [PTR_W:0]     PTR_ONE  = (PTR_W + 1)'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_OUT - 1);
  localparam logic [CALC_W-1:0]  POT_MAX  = CALC_W'({POT_W{1'b1}});

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_SUM  = 3'd2,
    S_UPD  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t state;

  // Per-channel FIFO status and head-of-queue values, flattened per channel.
  logic [N_CH-1:0]       empty;
  logic [N_CH-1:0]       full;
  logic [N_CH*SUM_W-1:0] head_flat;
  logic                  pop;
  logic                  all_empty;
  logic                  all_nonempty;

  // Datapath registers between pipeline steps.
  logic [N_CH*SUM_W-1:0] ch_val_q;
  logic [SUMT_W-1:0]     sum_c;
  logic [SUMT_W-1:0]     sum_q;
  logic [POT_W-1:0]      mem_rd_q;

  // Neuron bookkeeping.
  logic [IDX_W-1:0]      idx;
  logic                  ts_pending;

  // Membrane potential storage. It is deliberately never reset: during the
  // first timestep first_ts masks whatever it holds.
  logic [POT_W-1:0]      pot_mem [NUM_OUT];

  // Update-step arithmetic.
  logic [POT_W-1:0]      prev_pot;
  logic [CALC_W-1:0]     t_raw;
  logic                  t_neg;
  logic                  t_sat;
  logic [POT_W-1:0]      t_clamp;
  logic                  spike_c;
  logic [POT_W-1:0]      new_pot;

  // Every FIFO is popped together, and only in POP, which is reached only
  // when every FIFO holds at least one entry.
  assign pop          = (state == S_POP);
  assign all_empty    = &empty;
  assign all_nonempty = ~|empty;
  assign in_ready     = ~full;
  assign dbg_state    = state;

  for (genvar k = 0; k < N_CH; k++) begin : g_fifo
    logic [SUM_W-1:0] slot [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             push;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign push     = in_valid[k] && !full[k];
    assign empty[k] = (wr_ptr == rd_ptr);
    assign full[k]  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head_flat[k*SUM_W +: SUM_W] = slot[rd_ptr[PTR_W-1:0]];

    // Advance write pointer on push and read pointer on the joint pop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end

    // Store the pushed partial sum in arrival order.
    always_ff @(posedge clk) begin
      if (push) slot[wr_ptr[PTR_W-1:0]] <= in_data[k*SUM_W +: SUM_W];
    end
  end

  // Full-width sum of the popped partial sums; the width covers N_CH maxima.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N_CH; k++) begin
      sum_c = sum_c + SUMT_W'(ch_val_q[k*SUM_W +: SUM_W]);
    end
  end

  // Leaky integrate with floor at zero, saturation at the top, strict
  // threshold compare and the selected post-spike reset.
  always_comb begin
    prev_pot = first_ts ? '0 : mem_rd_q;
    t_raw    = CALC_W'(prev_pot) + CALC_W'(sum_q) - CALC_W'(leak);
    t_neg    = t_raw[CALC_W-1];
    t_sat    = !t_neg && (t_raw > POT_MAX);
    if (t_neg) begin
      t_clamp = '0;
    end else if (t_sat) begin
      t_clamp = '1;
    end else begin
      t_clamp = t_raw[POT_W-1:0];
    end
    spike_c = (t_clamp > threshold);
    new_pot = t_clamp;
    if (spike_c) begin
      if (RESET_MODE == 0) begin
        new_pot = t_clamp - threshold;
      end else begin
        new_pot = '0;
      end
    end
  end

  // Read the neuron's stored potential in SUM, write the update back in UPD.
  always_ff @(posedge clk) begin
    if (state == S_SUM) mem_rd_q <= pot_mem[idx];
    if (state == S_UPD) pot_mem[idx] <= new_pot;
  end

  // Control FSM, neuron index, timestep tracking and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      first_ts      <= 1'b1;
      ts_pending    <= 1'b0;
      err           <= '0;
      out_valid     <= 1'b0;
      out_idx       <= '0;
      out_potential <= '0;
      out_spike     <= 1'b0;
      ch_val_q      <= '0;
      sum_q         <= '0;
    end else begin
      // A ts_done pulse is remembered in any state until it can be applied.
      ts_pending <= ts_pending | ts_done;

      case (state)
        S_IDLE: begin
          if (ts_pending && all_empty) begin
            // Timestep boundary; a ts_done arriving now is absorbed by it.
            first_ts   <= 1'b0;
            ts_pending <= 1'b0;
            if (idx != '0) begin
              err[0] <= 1'b1;
              idx    <= '0;
            end
          end else if (all_nonempty) begin
            state <= S_POP;
          end
        end

        S_POP: begin
          ch_val_q <= head_flat;
          state    <= S_SUM;
        end

        S_SUM: begin
          sum_q <= sum_c;
          state <= S_UPD;
        end

        S_UPD: begin
          if (t_sat) err[1] <= 1'b1;
          out_idx       <= idx;
          out_potential <= new_pot;
          out_spike     <= spike_c;
          out_valid     <= 1'b1;
          state         <= S_OUT;
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            idx       <= (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spe_accum_array.sv
// Directed bench for spe_accum_array. Two instances share all inputs: dut_a
// subtracts the threshold on a spike, dut_b resets the potential to zero.
// NUM_OUT is 4 so index wrap and timestep changes are reached quickly.
module tb_spe_accum_array;

  localparam int N_CH    = 5;
  localparam int SUM_W   = 13;
  localparam int POT_W   = 13;
  localparam int DEPTH   = 8;
  localparam int NUM_OUT = 4;
  localparam int IDX_W   = 2;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N_CH-1:0]       in_valid;
  logic [N_CH*SUM_W-1:0] in_data;
  logic                  ts_done;
  logic [POT_W-1:0]      threshold;
  logic [POT_W-1:0]      leak;
  logic                  out_ready;

  logic [N_CH-1:0]  in_ready,      in_ready_b;
  logic             out_valid,     out_valid_b;
  logic [IDX_W-1:0] out_idx,       out_idx_b;
  logic [POT_W-1:0] out_potential, out_potential_b;
  logic             out_spike,     out_spike_b;
  logic             first_ts,      first_ts_b;
  logic [1:0]       err,           err_b;
  logic [2:0]       dbg_state,     dbg_state_b;

  spe_accum_array #(
    .N_CH(N_CH), .SUM_W(SUM_W), .POT_W(POT_W), .DEPTH(DEPTH),
    .NUM_OUT(NUM_OUT), .RESET_MODE(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ts_done(ts_done), .threshold(threshold),
    .leak(leak), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_potential(out_potential), .out_spike(out_spike),
    .first_ts(first_ts), .err(err), .dbg_state(dbg_state)
  );

  spe_accum_array #(
    .N_CH(N_CH), .SUM_W(SUM_W), .POT_W(POT_W), .DEPTH(DEPTH),
    .NUM_OUT(NUM_OUT), .RESET_MODE(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .ts_done(ts_done), .threshold(threshold),
    .leak(leak), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_idx(out_idx_b), .out_potential(out_potential_b),
    .out_spike(out_spike_b), .first_ts(first_ts_b), .err(err_b),
    .dbg_state(dbg_state_b)
  );

  int checks = 0;
  int errors = 0;

  // Expected records of the skewed-arrival drain (entry k of channel c = 10k+c).
  int exp_idx [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_pa  [8] = '{21, 62, 8191, 216, 231, 322, 8191, 576};
  int exp_pb  [8] = '{10, 62, 110, 180, 220, 322, 420, 540};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver: push one value per masked channel in the same cycle.
  // Entered and left on a falling edge.
  task automatic push(input logic [4:0] mask, input int v0, input int v1,
                      input int v2, input int v3, input int v4);
    int n;
    n = 0;
    in_data  = {SUM_W'(v4), SUM_W'(v3), SUM_W'(v2), SUM_W'(v1), SUM_W'(v0)};
    while (((in_ready & mask) != mask) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if ((in_ready & mask) != mask) begin
      check("push_ready", 32'(in_ready & mask), 32'(mask));
    end else begin
      in_valid = mask;
      @(posedge clk);
      @(negedge clk);
      in_valid = '0;
    end
  endtask

  // Wait (bounded) for a record and compare it on both instances.
  task automatic wait_rec(input string tag, input int eidx, input int pa,
                          input int sa, input int pb, input int sb);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 1);
    if (out_valid) begin
      check({tag, "_idx"},     32'(out_idx),         eidx);
      check({tag, "_pot_a"},   32'(out_potential),   pa);
      check({tag, "_spike_a"}, 32'(out_spike),       sa);
      check({tag, "_pot_b"},   32'(out_potential_b), pb);
      check({tag, "_spike_b"}, 32'(out_spike_b),     sb);
      if (out_ready) @(negedge clk);
    end
  endtask

  task automatic pulse_ts_done();
    ts_done = 1'b1;
    @(negedge clk);
    ts_done = 1'b0;
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    ts_done   = 1'b0;
    threshold = 13'd64;
    leak      = 13'd0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_idx",   32'(out_idx), 0);
    check("rst_out_pot",   32'(out_potential), 0);
    check("rst_out_spike", 32'(out_spike), 0);
    check("rst_err",       32'(err), 0);
    check("rst_first_ts",  32'(first_ts), 1);
    check("rst_in_ready",  32'(in_ready), 32'h1f);

    // Timestep 1, idx 0: sum 45, record four edges after the push edge.
    push(5'h1f, 10, 20, 5, 7, 3);
    repeat (3) @(negedge clk);
    check("lat_early", 32'(out_valid), 0);
    @(negedge clk);
    check("lat_on", 32'(out_valid), 1);
    wait_rec("r1", 0, 45, 0, 45, 0);

    // idx 1: sum 3 minus leak 5 floors at zero without raising err.
    leak = 13'd5;
    push(5'h1f, 1, 1, 1, 0, 0);
    wait_rec("r2", 1, 0, 0, 0, 0);
    check("floor_err", 32'(err), 0);

    // idx 2: 8000 under threshold 8191, no spike.
    leak = 13'd0;
    threshold = 13'd8191;
    push(5'h1f, 8000, 0, 0, 0, 0);
    wait_rec("r3", 2, 8000, 0, 8000, 0);

    // idx 3: 100 > 64 spikes; index wraps to 0 afterwards.
    threshold = 13'd64;
    push(5'h1f, 100, 0, 0, 0, 0);
    wait_rec("r4", 3, 36, 1, 0, 1);
    check("wrap_first_ts", 32'(first_ts), 1);

    // Timestep change at idx 0 with empty FIFOs.
    pulse_ts_done();
    @(negedge clk);
    check("ts1_first_ts", 32'(first_ts), 0);
    check("ts1_err", 32'(err), 0);

    // Timestep 2: prev 45 + 30 = 75 > 64.
    push(5'h1f, 10, 10, 10, 0, 0);
    wait_rec("r5", 0, 11, 1, 0, 1);
    push(5'h1f, 2, 0, 0, 0, 0);
    wait_rec("r6", 1, 2, 0, 2, 0);

    // Saturation: 8000 + 500 clamps to 8191, then spikes.
    push(5'h1f, 500, 0, 0, 0, 0);
    wait_rec("r7", 2, 8127, 1, 0, 1);
    check("sat_err", 32'(err), 2);

    // Back-pressure: hold the idx 3 record while filling FIFOs.
    out_ready = 1'b0;
    push(5'h1f, 20, 0, 0, 0, 0);
    wait_rec("r8", 3, 56, 0, 20, 0);
    threshold = 13'd8191;
    for (int k = 0; k < 8; k++) push(5'h01, 10 * k, 0, 0, 0, 0);
    check("bp_ready_ch0", 32'(in_ready), 32'h1e);
    for (int k = 0; k < 8; k++) push(5'h0e, 0, 10 * k + 1, 10 * k + 2, 10 * k + 3, 0);
    for (int k = 0; k < 2; k++) push(5'h10, 0, 0, 0, 0, 10 * k + 4);
    check("bp_ready_all", 32'(in_ready), 32'h10);
    check("bp_hold_valid", 32'(out_valid), 1);
    check("bp_hold_idx", 32'(out_idx), 3);
    check("bp_hold_pot", 32'(out_potential), 56);
    out_ready = 1'b1;
    @(negedge clk);

    // Skewed arrival: only two complete sets exist.
    for (int k = 0; k < 2; k++) begin
      wait_rec($sformatf("skew%0d", k), exp_idx[k], exp_pa[k], 0, exp_pb[k], 0);
    end
    seen = 0;
    repeat (8) begin
      if (out_valid) seen = 1;
      @(negedge clk);
    end
    check("skew_stall", 32'(seen), 0);
    out_ready = 1'b0;
    for (int k = 2; k < 8; k++) push(5'h10, 0, 0, 0, 0, 10 * k + 4);
    out_ready = 1'b1;
    for (int k = 2; k < 8; k++) begin
      wait_rec($sformatf("skew%0d", k), exp_idx[k], exp_pa[k], 0, exp_pb[k], 0);
    end
    check("skew_err", 32'(err), 2);

    // ts_done during a record at idx 1, with a FIFO left non-empty.
    push(5'h1f, 1, 0, 0, 0, 0);
    wait_rec("d0", 0, 232, 0, 221, 0);
    out_ready = 1'b0;
    push(5'h1f, 2, 0, 0, 0, 0);
    wait_rec("d1", 1, 324, 0, 324, 0);
    pulse_ts_done();
    push(5'h01, 3, 0, 0, 0, 0);
    check("defer_err_out", 32'(err), 2);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("defer_err_idle", 32'(err), 2);
    check("defer_no_rec", 32'(out_valid), 0);
    push(5'h1e, 0, 0, 0, 0, 0);
    wait_rec("d2", 2, 8191, 0, 423, 0);
    repeat (2) @(negedge clk);
    check("defer_err_set", 32'(err), 3);
    push(5'h1f, 4, 0, 0, 0, 0);
    wait_rec("d_forced", 0, 236, 0, 225, 0);

    // Reset while a record is held in OUT.
    out_ready = 1'b0;
    push(5'h1f, 7, 0, 0, 0, 0);
    wait_rec("pre_rst", 1, 331, 0, 331, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_first_ts", 32'(first_ts), 1);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_idx", 32'(out_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'h1f);
    push(5'h1f, 5, 0, 0, 0, 0);
    wait_rec("post_rst", 0, 5, 0, 5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
